// File: rtl/ctrl_issue_unit.sv
// ctrl_issue_unit: registered opcode decoder with FP latency stall and STOP halt sequencing.
// Optional CTRL_PERF_CNT_EN adds issued/stall performance counters.
module ctrl_issue_unit #(
  parameter int OP_WIDTH  = 4,
  parameter int CV_WIDTH  = 11,
  parameter int ADDF_LAT  = 2,
  parameter int MULTF_LAT = 3,
  parameter int CNT_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_WIDTH-1:0] opcode_i,
  input  logic                valid_i,
  input  logic                flush_i,
  output logic [CV_WIDTH-1:0] cv_o,
  output logic                reg_write,
  output logic                alu_op,
  output logic                branch,
  output logic                mem_read,
  output logic                reg_dst,
  output logic                mem_write,
  output logic                jump,
  output logic                mem_to_reg,
  output logic                mov,
  output logic                floating,
  output logic                stop,
  output logic                stall_o,
  output logic                halted_o,
  output logic                illegal_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]         issued_cnt_o,
  output logic [31:0]         stall_cnt_o
`endif
);
  typedef enum logic [1:0] {RUN, FP_WAIT, HALT} state_t;
  localparam logic [OP_WIDTH-1:0] OP_STOP  = OP_WIDTH'(4'b0111);
  localparam logic [OP_WIDTH-1:0] OP_ADDF  = OP_WIDTH'(4'b1000);
  localparam logic [OP_WIDTH-1:0] OP_MULTF = OP_WIDTH'(4'b1001);
  localparam logic [CNT_W-1:0] ADDF_LD  = CNT_W'(ADDF_LAT - 1);
  localparam logic [CNT_W-1:0] MULTF_LD = CNT_W'(MULTF_LAT - 1);
  if (ADDF_LAT < 1 || MULTF_LAT < 1 || ADDF_LAT - 1 > 2**CNT_W - 1 || MULTF_LAT - 1 > 2**CNT_W - 1) begin : g_bad_cfg
    $error("ctrl_issue_unit: FP latency out of range for CNT_W");
  end
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [CV_WIDTH-1:0] dec;
  logic legal, take, is_addf, is_multf, long_fp;
  always_comb begin
    dec = '0;
    legal = 1'b1;
    case (opcode_i)
      OP_WIDTH'(4'b0000): dec = CV_WIDTH'(11'b10011001000);
      OP_WIDTH'(4'b0001): dec = CV_WIDTH'(11'b00000100000);
      OP_WIDTH'(4'b0010): dec = CV_WIDTH'(11'b10000000000);
      OP_WIDTH'(4'b0011): dec = CV_WIDTH'(11'b10001000100);
      OP_WIDTH'(4'b0100): dec = CV_WIDTH'(11'b11000000000);
      OP_WIDTH'(4'b0101): dec = CV_WIDTH'(11'b00100000000);
      OP_STOP:            dec = CV_WIDTH'(11'b00000000001);
      OP_ADDF, OP_MULTF:  dec = CV_WIDTH'(11'b10000000010);
      OP_WIDTH'(4'b1111): dec = '0;
      default:            legal = 1'b0;
    endcase
  end
  assign take     = state == RUN && valid_i && !flush_i;
  assign is_addf  = opcode_i == OP_ADDF;
  assign is_multf = opcode_i == OP_MULTF;
  assign long_fp  = (is_addf && ADDF_LAT > 1) || (is_multf && MULTF_LAT > 1);
  assign stall_o  = state != RUN;
  assign {reg_write, alu_op, branch, mem_read, reg_dst, mem_write, jump, mem_to_reg, mov, floating, stop} = cv_o;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      cnt       <= '0;
      cv_o      <= '0;
      halted_o  <= 1'b0;
      illegal_o <= 1'b0;
    end else begin
      cv_o      <= take ? dec : '0;
      illegal_o <= take && !legal;
      case (state)
        RUN: begin
          if (take && long_fp) begin
            cnt   <= is_multf ? MULTF_LD : ADDF_LD;
            state <= FP_WAIT;
          end else if (take && opcode_i == OP_STOP) begin
            state    <= HALT;
            halted_o <= 1'b1;
          end
        end
        FP_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= RUN;
        end
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase
    end
  end
`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt_o <= '0;
      stall_cnt_o  <= '0;
    end else if (state != HALT) begin
      issued_cnt_o <= issued_cnt_o + 32'(cv_o != '0);
      stall_cnt_o  <= stall_cnt_o + 32'(stall_o);
    end
  end
`endif
endmodule

// File: tb/tb_ctrl_issue_unit.sv
// tb_ctrl_issue_unit: directed stimulus checked against a cycle-level model of the issue rules.
module tb_ctrl_issue_unit;
  localparam int ADDF_LAT = 2, MULTF_LAT = 3;
  logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, flush = 1'b0;
  logic [3:0] opcode = '0;
  logic [10:0] cv;
  logic reg_write, alu_op, branch, mem_read, reg_dst, mem_write, jump, mem_to_reg, mov, floating, stop;
  logic stall, halted, illegal;
  int tests = 0, failed = 0;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] issued_cnt, stall_cnt, issued_base, stall_base;
`endif
  ctrl_issue_unit #(.ADDF_LAT(ADDF_LAT), .MULTF_LAT(MULTF_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .valid_i(valid), .flush_i(flush), .cv_o(cv),
    .reg_write(reg_write), .alu_op(alu_op), .branch(branch), .mem_read(mem_read), .reg_dst(reg_dst),
    .mem_write(mem_write), .jump(jump), .mem_to_reg(mem_to_reg), .mov(mov), .floating(floating), .stop(stop),
    .stall_o(stall), .halted_o(halted), .illegal_o(illegal)
`ifdef CTRL_PERF_CNT_EN
    , .issued_cnt_o(issued_cnt), .stall_cnt_o(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [10:0] cv_of(input logic [3:0] op);
    case (op)
      4'd0: return 11'b10011001000;
      4'd1: return 11'b00000100000;
      4'd2: return 11'b10000000000;
      4'd3: return 11'b10001000100;
      4'd4: return 11'b11000000000;
      4'd5: return 11'b00100000000;
      4'd7: return 11'b00000000001;
      4'd8, 4'd9: return 11'b10000000010;
      default: return 11'b0;
    endcase
  endfunction
  function automatic bit legal_op(input logic [3:0] op);
    return op inside {[4'd0:4'd5], 4'd7, 4'd8, 4'd9, 4'd15};
  endfunction
  logic [10:0] m_cv;
  logic m_ill, m_halt;
  int m_wait;
  wire issue = valid && !flush;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cv <= '0; m_ill <= 1'b0; m_halt <= 1'b0; m_wait <= 0;
    end else if (m_halt || m_wait > 0) begin
      m_cv <= '0; m_ill <= 1'b0;
      if (m_wait > 0) m_wait <= m_wait - 1;
    end else begin
      m_cv  <= issue ? cv_of(opcode) : 11'b0;
      m_ill <= issue && !legal_op(opcode);
      if (issue && (opcode == 4'd8 || opcode == 4'd9)) m_wait <= (opcode == 4'd9 ? MULTF_LAT : ADDF_LAT) - 1;
      if (issue && opcode == 4'd7) m_halt <= 1'b1;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    chk("model cv", 32'(cv), 32'(m_cv));
    chk("model bits", 32'({reg_write, alu_op, branch, mem_read, reg_dst, mem_write, jump, mem_to_reg, mov, floating, stop}), 32'(m_cv));
    chk("model stall", 32'(stall), 32'(m_halt || m_wait > 0));
    chk("model halted", 32'(halted), 32'(m_halt));
    chk("model illegal", 32'(illegal), 32'(m_ill));
  end
  task automatic step(input logic [3:0] op, input logic v, input logic f);
    opcode = op; valid = v; flush = f;
    @(negedge clk);
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, " cv"}, 32'(cv), 0);
    chk({nm, " stall"}, 32'(stall), 0);
    chk({nm, " halted"}, 32'(halted), 0);
    chk({nm, " illegal"}, 32'(illegal), 0);
  endtask
  logic [3:0]  t1_op [7] = '{4'd2, 4'd4, 4'd0, 4'd1, 4'd3, 4'd5, 4'd15};
  logic [10:0] t1_cv [7] = '{11'b10000000000, 11'b11000000000, 11'b10011001000, 11'b00000100000,
                             11'b10001000100, 11'b00100000000, 11'b0};
  initial begin
    #100000 $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(t1_op[i], 1'b1, 1'b0);
      chk("t1 cv", 32'(cv), 32'(t1_cv[i]));
      chk("t1 stall", 32'(stall), 0);
    end
    step(4'd0, 1'b0, 1'b0);
`ifdef CTRL_PERF_CNT_EN
    issued_base = issued_cnt; stall_base = stall_cnt;
`endif
    step(4'd9, 1'b1, 1'b0);
    chk("t2 fp cv", 32'(cv), 32'(11'b10000000010));
    chk("t2 stall0", 32'(stall), 1);
    step(4'd2, 1'b1, 1'b0);
    chk("t2 bubble cv", 32'(cv), 0);
    chk("t2 stall1", 32'(stall), 1);
    step(4'd2, 1'b1, 1'b0);
    chk("t2 stall2", 32'(stall), 0);
    step(4'd2, 1'b1, 1'b0);
    chk("t2 add cv", 32'(cv), 32'(11'b10000000000));
    step(4'd0, 1'b0, 1'b0);
`ifdef CTRL_PERF_CNT_EN
    chk("perf issued", issued_cnt - issued_base, 2);
    chk("perf stall", stall_cnt - stall_base, 2);
`endif
    step(4'd7, 1'b1, 1'b1);
    chk("t4 flush stop cv", 32'(cv), 0);
    chk("t4 flush stop halted", 32'(halted), 0);
    step(4'd8, 1'b1, 1'b1);
    chk("t4 flush addf stall", 32'(stall), 0);
    step(4'd9, 1'b1, 1'b0);
    step(4'd2, 1'b1, 1'b1);
    chk("t4 flush in wait stall", 32'(stall), 1);
    step(4'd2, 1'b1, 1'b1);
    step(4'd2, 1'b1, 1'b0);
    chk("t4 add after wait", 32'(cv), 32'(11'b10000000000));
    step(4'd8, 1'b1, 1'b0);
    step(4'd8, 1'b1, 1'b0);
    step(4'd8, 1'b1, 1'b0);
    chk("b2b addf cv", 32'(cv), 32'(11'b10000000010));
    chk("b2b addf stall", 32'(stall), 1);
    step(4'd6, 1'b1, 1'b0);
    step(4'd6, 1'b1, 1'b0);
    chk("t5 illegal pulse", 32'(illegal), 1);
    chk("t5 illegal cv", 32'(cv), 0);
    step(4'd0, 1'b0, 1'b0);
    chk("t5 pulse ends", 32'(illegal), 0);
    step(4'd6, 1'b0, 1'b0);
    chk("t5 invalid no pulse", 32'(illegal), 0);
    step(4'd6, 1'b1, 1'b1);
    chk("t5 flush no pulse", 32'(illegal), 0);
    step(4'hA, 1'b1, 1'b0);
    chk("t5 opA pulse", 32'(illegal), 1);
    step(4'd9, 1'b1, 1'b0);
    chk("t6 pre stall", 32'(stall), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset("t6 async");
    @(negedge clk);
    opcode = 4'd0; valid = 1'b0; flush = 1'b0;
    rst_n = 1'b1;
    step(4'd2, 1'b1, 1'b0);
    chk("t6 after reset cv", 32'(cv), 32'(11'b10000000000));
    step(4'd7, 1'b1, 1'b0);
    chk("t3 stop cv", 32'(cv), 32'(11'b00000000001));
    chk("t3 halted", 32'(halted), 1);
    for (int i = 0; i < 12; i++) step(4'd2, 1'b1, i[0]);
    chk("t3 held cv", 32'(cv), 0);
    chk("t3 held halted", 32'(halted), 1);
    chk("t3 held stall", 32'(stall), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset("t3 reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(4'd4, 1'b1, 1'b0);
    chk("t3 resume cv", 32'(cv), 32'(11'b11000000000));
    step(4'd0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
